nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl.sv | 138 +++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial W-bit adder: one shared 4-bit slice steps LSB nibble first, carry held in a register.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_SUB_EN (adds the 'sub' input).
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [3:0]       nib_a, nib_b;
  logic [4:0]       nib_res;
  logic [W-1:0]     b_load;
  logic             c_load;

  // One 4-bit slice of the ripple: {carry_out, sum_nibble}
  function automatic logic [4:0] nib_add(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       c);
    return {1'b0, x} + {1'b0, y} + {4'b0000, c};
  endfunction

  // Subtraction is a + ~b + 1, so the operand inversion happens once at latch time
  always_comb begin
`ifdef NIBBLE_SERIAL_SUB_EN
    b_load = sub ? ~b : b;
    c_load = sub | cin;
`else
    b_load = b;
    c_load = cin;
`endif
  end

  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        nib_a = a_q[4*n +: 4];
        nib_b = b_q[4*n +: 4];
      end
    end
    nib_res = nib_add(nib_a, nib_b, carry_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b_load;
          carry_d = c_load;
          idx_d   = '0;
          sum_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == IDX_W'(n)) sum_d[4*n +: 4] = nib_res[3:0];
        end
        carry_d = nib_res[4];
        if (idx_q == LAST_IDX) begin
          cout_d  = nib_res[4];
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl (NIBBLES=4).
module tb_nibble_serial_adder_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic         sub;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef NIBBLE_SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive operands with start for one edge; returns 1 ns after the accepting edge
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a = av; b = bv; cin = cv; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", busy, done);
    end
    checks++;
    if (sum !== 16'h0000 || cout !== 1'b0) begin
      errors++; $display("FAIL reset_data: sum=%h cout=%b, required 0000 0", sum, cout);
    end
    rst = 1'b0; start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_start_ignored: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    start_op(16'h0001, 16'h0001, 1'b0);
    for (int i = 0; i < NIB; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL basic_busy cycle %0d: busy=%b done=%b, required 1 0", i, busy, done);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done: done=%b busy=%b, required 1 0", done, busy);
    end
    checks++;
    if (sum !== 16'h0002 || cout !== 1'b0) begin
      errors++; $display("FAIL basic_result: sum=%h cout=%b, required 0002 0", sum, cout);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 16'h0002) begin
      errors++; $display("FAIL basic_hold: done=%b busy=%b sum=%h, required 0 0 0002", done, busy, sum);
    end
  endtask

  task automatic test_carry_ripple();
    start_op(16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < NIB; i++) step();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL ripple_done: done=%b, required 1", done);
    end
    checks++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      errors++; $display("FAIL ripple_result: sum=%h cout=%b, required 0000 1", sum, cout);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    saw_done = 1'b0;
    start_op(16'h1234, 16'h1111, 1'b0);
    step();
    step();
    checks++;
    if (sum !== 16'h0045 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_partial: sum=%h busy=%b, required 0045 1", sum, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: busy=%b done=%b sum=%h cout=%b, required 0 0 0000 0", busy, done, sum, cout);
    end
    for (int i = 0; i < NIB + 2; i++) begin
      step();
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL midrst_no_done: done seen=%b, required 0", saw_done);
    end
    start_op(16'h1234, 16'h1111, 1'b0);
    for (int i = 0; i < NIB; i++) step();
    checks++;
    if (done !== 1'b1 || sum !== 16'h2345 || cout !== 1'b0) begin
      errors++; $display("FAIL midrst_fresh: done=%b sum=%h cout=%b, required 1 2345 0", done, sum, cout);
    end
    step();
  endtask

  task automatic test_back_to_back();
    start_op(16'h8F0F, 16'h80F1, 1'b1);
    step();
    // start and operand changes mid-run must not disturb the operation
    start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_ignore_busy: busy=%b done=%b, required 1 0", busy, done);
    end
    step();
    step();
    checks++;
    if (done !== 1'b1 || sum !== 16'h1001 || cout !== 1'b1) begin
      errors++; $display("FAIL b2b_first: done=%b sum=%h cout=%b, required 1 1001 1", done, sum, cout);
    end
    start = 1'b1; a = 16'h0100; b = 16'h0022; cin = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sum !== 16'h0000) begin
      errors++; $display("FAIL b2b_restart: busy=%b done=%b sum=%h, required 1 0 0000", busy, done, sum);
    end
    for (int i = 0; i < NIB; i++) step();
    checks++;
    if (done !== 1'b1 || sum !== 16'h0122 || cout !== 1'b0) begin
      errors++; $display("FAIL b2b_second: done=%b sum=%h cout=%b, required 1 0122 0", done, sum, cout);
    end
    step();
  endtask

`ifdef NIBBLE_SERIAL_SUB_EN
  task automatic test_sub();
    sub = 1'b1;
    start_op(16'h0005, 16'h0007, 1'b0);
    sub = 1'b0;
    for (int i = 0; i < NIB; i++) step();
    checks++;
    if (done !== 1'b1 || sum !== 16'hFFFE || cout !== 1'b0) begin
      errors++; $display("FAIL sub_borrow: done=%b sum=%h cout=%b, required 1 fffe 0", done, sum, cout);
    end
    step();
    sub = 1'b1;
    start_op(16'h0007, 16'h0005, 1'b0);
    sub = 1'b0;
    for (int i = 0; i < NIB; i++) step();
    checks++;
    if (done !== 1'b1 || sum !== 16'h0002 || cout !== 1'b1) begin
      errors++; $display("FAIL sub_noborrow: done=%b sum=%h cout=%b, required 1 0002 1", done, sum, cout);
    end
    step();
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub = 1'b0;
`endif
    test_reset();
    test_basic();
    test_carry_ripple();
    test_reset_mid();
    test_back_to_back();
`ifdef NIBBLE_SERIAL_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
